ram_responder: RTL
==================

// Module: ram_responder
// PURPOSE
//  Memory-side end of the 8-bit CPU bus: answers the CPU's ram_addr/ram_data/ram_rw
//  requests with ram_out read data, and owns the program RAM. After reset it holds the CPU
//  while a byte-stream loader (valid/ready) fills memory from address 0, then releases it.
//  Sits beside the microprocessor at top level; the CPU's ram_out is driven from cpu_rdata.
// PARAMETERS
//  ADDR_W     8      address width; DEPTH = 1<<ADDR_W bytes
//  DATA_W     8      data width
//  MMIO_ADDR  8'hFF  address of the output port (used only with RAM_MMIO_PORT_EN)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  cpu_addr    in   ADDR_W  CPU address (ram_addr)
//  cpu_wdata   in   DATA_W  CPU write data (ram_data)
//  cpu_rw      in   1       1 = write, 0 = read (ram_rw)
//  cpu_rdata   out  DATA_W  registered read data (to CPU ram_out)
//  cpu_hold    out  1       1 = CPU must stall (gate its clock enable)
//  load_start  in   1       pulse: (re)start loading at address 0
//  load_valid  in   1       loader byte valid
//  load_data   in   DATA_W  loader byte
//  load_last   in   1       marks final byte of image (qualified by valid)
//  load_ready  out  1       responder accepts a loader byte this cycle
//  loaded_len  out  ADDR_W+1  bytes written by the last/current load (0..DEPTH)
//  io_out      out  DATA_W  output port register (only with RAM_MMIO_PORT_EN)
// BEHAVIOUR
//  Reset: state=LOAD, ptr=0, loaded_len=0, cpu_rdata=0, cpu_hold=1, load_ready=1, io_out=0.
//  Memory contents are NOT reset.
//  States: LOAD, RUN. cpu_hold = (state==LOAD); load_ready = (state==LOAD).
//  LOAD: byte accepted when load_valid&&load_ready: mem[ptr]<=load_data, ptr++, loaded_len++.
//   -> RUN on the cycle after accepting a byte with load_last=1, or accepting ptr==DEPTH-1
//      (pointer wrap ends load; loaded_len=DEPTH). Never wraps to overwrite address 0.
//   CPU inputs ignored; cpu_rdata held at 0.
//  RUN: every cycle cpu_rdata <= mem[cpu_addr] (1-cycle latency, registered).
//   cpu_rw=1: mem[cpu_addr] <= cpu_wdata at the edge; same-cycle read returns OLD data
//   (read-before-write). load_valid ignored, load_ready=0.
//  load_start: in either state -> LOAD, ptr=0, loaded_len=0 next cycle; cpu_hold=1 from next
//   cycle. Simultaneous load_start and accepted byte: load_start wins, byte discarded.
//  load_start and rst together: rst wins. Reset mid-load: load aborted, partial image kept.
//  Release: cpu_hold falls the cycle after final byte accepted; first CPU read is valid
//   one cycle after cpu_hold=0 is sampled.
// CONFIGURATION
//  RAM_MMIO_PORT_EN defined: io_out port present; in RUN, a write to MMIO_ADDR updates io_out
//   (memory untouched) and a read of MMIO_ADDR returns io_out. Loader writes to MMIO_ADDR
//   still go to memory.
//  Not defined: no io_out port; MMIO_ADDR is ordinary RAM.
// STRUCTURE
//  Shared package ram_pkg: ADDR_W/DATA_W defaults, state encoding (ST_LOAD, ST_RUN),
//   RW_READ/RW_WRITE constants, MMIO_ADDR default.
//  One sub-module: ram_array (single-port sync write, registered read, read-before-write);
//   ram_responder holds FSM, load pointer, write-port mux (loader vs CPU) and MMIO decode.
// TESTING
//  1 Reset, load bytes 0x11,0x22,0x33 (last on 0x33) -> cpu_hold=1 throughout, loaded_len=3,
//    cpu_hold=0 next cycle; CPU read addr 1 -> cpu_rdata=0x22 one cycle later.
//  2 Load with load_valid gaps and 256 bytes, no load_last -> RUN after byte 255, loaded_len=256,
//    mem[0] still first byte.
//  3 RUN: write 0x5A to 0x10 then read 0x10 same cycle -> old value; next read -> 0x5A.
//  4 load_start asserted with valid byte in RUN and in LOAD -> byte discarded, ptr=0,
//    loaded_len=0, cpu_hold=1 next cycle, cpu_rdata=0.
//  5 rst mid-load after 2 bytes -> all outputs at reset values, mem[0..1] retained.
//  6 RAM_MMIO_PORT_EN: write 0xA5 to 0xFF -> io_out=0xA5, mem[0xFF] unchanged; read 0xFF -> 0xA5;
//    without macro same write stored in memory.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM responder: default widths, FSM state
// encoding, CPU read/write encoding and the default output-port address.
package ram_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    // Default address of the memory-mapped output port
    localparam logic [7:0] MMIO_ADDR_DEF = 8'hFF;

    // Encoding of the CPU ram_rw line
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_responder_if.sv
// Bus bundle between the CPU/loader side (master) and the RAM responder (slave).
// Optional feature macro: RAM_MMIO_PORT_EN adds the io_out output-port signal.
interface ram_responder_if
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    // CPU bus
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hold;

    // Byte-stream loader
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W:0]   loaded_len;

`ifdef RAM_MMIO_PORT_EN
    logic [DATA_W-1:0] io_out;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rw, load_start, load_valid, load_data, load_last,
        input  cpu_rdata, cpu_hold, load_ready, loaded_len, io_out
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rw, load_start, load_valid, load_data, load_last,
        output cpu_rdata, cpu_hold, load_ready, loaded_len, io_out
    );
`else
    modport master (
        output cpu_addr, cpu_wdata, cpu_rw, load_start, load_valid, load_data, load_last,
        input  cpu_rdata, cpu_hold, load_ready, loaded_len
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rw, load_start, load_valid, load_data, load_last,
        output cpu_rdata, cpu_hold, load_ready, loaded_len
    );
`endif

endinterface

// File: rtl/ram_array.sv
// Single-port byte RAM: synchronous write, registered read, read-before-write.
// The read register can be cleared so the responder can hold its read data at 0.
module ram_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read samples the pre-write contents at the same edge
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the 8-bit CPU bus. After reset (or load_start) it holds the
// CPU while a valid/ready byte stream fills RAM from address 0, then serves CPU
// reads/writes with one cycle of read latency.
// Optional feature macro: RAM_MMIO_PORT_EN maps an output register at MMIO_ADDR.
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(MMIO_ADDR_DEF)
) (
    input logic            clk,
    input logic            rst,
    ram_responder_if.slave bus
);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   len_q;
    logic              hold_q;
    logic              ready_q;

    logic              accept;
    logic              cpu_wr;
    logic              mmio_hit;

    logic              arr_we;
    logic              arr_clr;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = (state_q == ST_LOAD) && bus.load_valid;
    assign cpu_wr = (state_q == ST_RUN) && (bus.cpu_rw == RW_WRITE);

    // Read data reads as zero while loading and on the edge that (re)enters LOAD
    assign arr_clr = rst || bus.load_start || (state_q == ST_LOAD);

    // Write-port mux: loader owns the array in LOAD, the CPU in RUN
    always_comb begin
        arr_we    = 1'b0;
        arr_addr  = bus.cpu_addr;
        arr_wdata = bus.cpu_wdata;
        if (state_q == ST_LOAD) begin
            arr_addr  = ptr_q;
            arr_wdata = bus.load_data;
            arr_we    = accept;
        end else begin
            arr_we = cpu_wr && !mmio_hit;
        end
        // Reset and restart both discard whatever transfer is on the bus
        if (rst || bus.load_start) begin
            arr_we = 1'b0;
        end
    end

    ram_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram_array (
        .clk  (clk),
        .clr  (arr_clr),
        .we   (arr_we),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    // Load/run FSM with load pointer, length counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            len_q   <= '0;
            hold_q  <= 1'b1;
            ready_q <= 1'b1;
        end else if (bus.load_start) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            len_q   <= '0;
            hold_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        ptr_q <= ptr_q + 1'b1;
                        len_q <= len_q + 1'b1;
                        // Top address ends the load so the pointer never wraps onto 0
                        if (bus.load_last || (ptr_q == {ADDR_W{1'b1}})) begin
                            state_q <= ST_RUN;
                            hold_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.cpu_hold   = hold_q;
    assign bus.load_ready = ready_q;
    assign bus.loaded_len = len_q;

`ifdef RAM_MMIO_PORT_EN
    logic [DATA_W-1:0] io_q;
    logic [DATA_W-1:0] mmio_rdata_q;
    logic              mmio_rd_q;

    assign mmio_hit = (bus.cpu_addr == MMIO_ADDR);

    // Output port register, written only by CPU stores in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            io_q <= '0;
        end else if (cpu_wr && mmio_hit && !bus.load_start) begin
            io_q <= bus.cpu_wdata;
        end
    end

    // Port read path mirrors the RAM: registered, returns the pre-write value
    always_ff @(posedge clk) begin
        if (arr_clr) begin
            mmio_rd_q    <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            mmio_rd_q    <= mmio_hit;
            mmio_rdata_q <= io_q;
        end
    end

    assign bus.cpu_rdata = mmio_rd_q ? mmio_rdata_q : arr_rdata;
    assign bus.io_out    = io_q;
`else
    logic unused_mmio_addr;

    assign mmio_hit         = 1'b0;
    assign unused_mmio_addr = ^MMIO_ADDR;
    assign bus.cpu_rdata    = arr_rdata;
`endif

endmodule
